// File: rtl/main_memory_responder.sv
// main_memory_responder: word-addressed backing store that answers the cache's
// mem_* requests after a fixed LATENCY, with a one-cycle mem_ready pulse and
// an error flag for out-of-range or conflicting (read+write) requests.
module main_memory_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_ready,
  output logic                  mem_error,
  output logic                  mem_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_reg;
  logic [7:0]              count_reg;
  logic [DEPTH_LOG2-1:0]   index_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic                    read_reg;
  logic                    write_reg;
  logic                    error_reg;

  // Backing store; deliberately has no reset so contents survive reset.
  logic [DATA_WIDTH-1:0]   store [DEPTH];

  // Decode of the live request inputs
  logic [DEPTH_LOG2-1:0]   in_index;
  logic                    in_range_err;
  logic                    in_request;
  logic                    unused_byte_bits;

  assign in_index         = mem_address[DEPTH_LOG2+1:2];
  assign in_request       = mem_read | mem_write;
  assign unused_byte_bits = ^mem_address[1:0];

  // Any address bit above the word index makes the request out of range.
  generate
    if (ADDR_WIDTH > DEPTH_LOG2 + 2) begin : g_range
      assign in_range_err = |mem_address[ADDR_WIDTH-1:DEPTH_LOG2+2];
    end else begin : g_no_range
      assign in_range_err = 1'b0;
    end
  endgenerate

  // Operation that completes this cycle: with LATENCY=1 it completes on the
  // acceptance edge straight from the inputs, otherwise from the latched copy.
  logic [DEPTH_LOG2-1:0]   op_index;
  logic [DATA_WIDTH-1:0]   op_wdata;
  logic                    op_read;
  logic                    op_write;
  logic                    op_error;
  logic                    do_op;

  // Select the source of the completing operation
  always_comb begin
    op_index = index_reg;
    op_wdata = wdata_reg;
    op_read  = read_reg;
    op_write = write_reg;
    op_error = error_reg;
    if (state_reg == IDLE) begin
      op_index = in_index;
      op_wdata = mem_data_out;
      op_read  = mem_read;
      op_write = mem_write;
      op_error = in_range_err | (mem_read & mem_write);
    end
  end

  // An operation finishes on the edge that enters RESP; reset_n gating keeps
  // an abandoned request from touching the store while reset is held.
  always_comb begin
    do_op = 1'b0;
    if (reset_n) begin
      if (state_reg == IDLE && in_request && LATENCY == 1) begin
        do_op = 1'b1;
      end else if (state_reg == BUSY && count_reg == 8'd1) begin
        do_op = 1'b1;
      end
    end
  end

  // Store write port: only successful writes update memory
  always_ff @(posedge clk) begin
    if (do_op && op_write && !op_error) begin
      store[op_index] <= op_wdata;
    end
  end

  // Request FSM with registered handshake outputs and read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      count_reg   <= 8'd0;
      index_reg   <= '0;
      wdata_reg   <= '0;
      read_reg    <= 1'b0;
      write_reg   <= 1'b0;
      error_reg   <= 1'b0;
      mem_ready   <= 1'b0;
      mem_error   <= 1'b0;
      mem_busy    <= 1'b0;
      mem_data_in <= '0;
    end else begin
      mem_ready <= 1'b0;
      mem_error <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_request) begin
            index_reg <= in_index;
            wdata_reg <= mem_data_out;
            read_reg  <= mem_read;
            write_reg <= mem_write;
            error_reg <= in_range_err | (mem_read & mem_write);
            count_reg <= 8'(LATENCY - 1);
            mem_busy  <= 1'b1;
            state_reg <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          count_reg <= count_reg - 8'd1;
          if (count_reg == 8'd1) begin
            state_reg <= RESP;
          end
        end
        RESP: begin
          // Request lines are not sampled here, so a held request is not re-accepted.
          mem_busy  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          mem_busy  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase

      if (do_op) begin
        mem_ready <= 1'b1;
        mem_error <= op_error;
        if (op_error) begin
          mem_data_in <= '0;
        end else if (op_read) begin
          mem_data_in <= store[op_index];
        end
      end
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: three instances at LATENCY 4, 1 and 8.
module tb_main_memory_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd   [3];
  logic        wr   [3];
  logic [31:0] dout [3];
  logic        rdy  [3];
  logic        err  [3];
  logic        busy [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  main_memory_responder #(.LATENCY(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .mem_address(addr), .mem_data_out(wdata),
    .mem_read(rd[0]), .mem_write(wr[0]), .mem_data_in(dout[0]),
    .mem_ready(rdy[0]), .mem_error(err[0]), .mem_busy(busy[0]));

  main_memory_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .mem_address(addr), .mem_data_out(wdata),
    .mem_read(rd[1]), .mem_write(wr[1]), .mem_data_in(dout[1]),
    .mem_ready(rdy[1]), .mem_error(err[1]), .mem_busy(busy[1]));

  main_memory_responder #(.LATENCY(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .mem_address(addr), .mem_data_out(wdata),
    .mem_read(rd[2]), .mem_write(wr[2]), .mem_data_in(dout[2]),
    .mem_ready(rdy[2]), .mem_error(err[2]), .mem_busy(busy[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on instance k. n = cycles from the cycle the request is first
  // presented until mem_ready is seen (-1 on timeout). after = busy|ready one
  // edge after the ready cycle (request still held when hold=1).
  task automatic req(input int k, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input bit hold, output int n, output logic e,
                     output logic [31:0] q, output logic busy_ok, output logic after);
    bit done = 0;
    addr = a; wdata = d; rd[k] = r; wr[k] = w;
    n = 0; e = 1'b0; q = '0; busy_ok = 1'b1;
    while (!done && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (!busy[k]) busy_ok = 1'b0;
      if (rdy[k]) begin
        done = 1;
        e = err[k];
        q = dout[k];
      end
    end
    if (!done) n = -1;
    if (hold) begin
      @(posedge clk); #1;
    end
    rd[k] = 1'b0; wr[k] = 1'b0;
    if (!hold) begin
      @(posedge clk); #1;
    end
    after = busy[k] | rdy[k];
    @(posedge clk); #1;
    $display("[TB] inst%0d rd=%0b wr=%0b addr=%h wdata=%h -> cycles=%0d err=%0b data=%h",
             k, r, w, a, d, n, e, q);
  endtask

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic e, bok, aft;
    logic [31:0] q;

    reset_n = 1'b0;
    addr = '0; wdata = '0;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, rdy[0]}, 32'd0);
    check("reset_error", {31'd0, err[0]}, 32'd0);
    check("reset_busy",  {31'd0, busy[0]}, 32'd0);
    check("reset_data",  dout[0], 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Known contents for words used later
    req(0, 1'b0, 1'b1, 32'h40, 32'h0000_0000, 0, n, e, q, bok, aft);
    req(0, 1'b0, 1'b1, 32'h00, 32'h600D_F00D, 0, n, e, q, bok, aft);

    // Write then read
    req(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, n, e, q, bok, aft);
    check("wr10_latency", n, 32'd4);
    check("wr10_error", {31'd0, e}, 32'd0);
    check("wr10_busy", {31'd0, bok}, 32'd1);
    req(0, 1'b1, 1'b0, 32'h10, 32'h0, 0, n, e, q, bok, aft);
    check("rd10_latency", n, 32'd4);
    check("rd10_error", {31'd0, e}, 32'd0);
    check("rd10_data", q, 32'hDEAD_BEEF);

    // Byte-offset alias; read data holds across the write
    req(0, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 0, n, e, q, bok, aft);
    check("wr20_data_hold", q, 32'hDEAD_BEEF);
    req(0, 1'b1, 1'b0, 32'h23, 32'h0, 0, n, e, q, bok, aft);
    check("rd23_alias", q, 32'h1234_5678);

    // Range errors
    req(0, 1'b1, 1'b0, 32'h1000, 32'h0, 0, n, e, q, bok, aft);
    check("rd1000_error", {31'd0, e}, 32'd1);
    check("rd1000_data", q, 32'd0);
    check("rd1000_latency", n, 32'd4);
    check("error_low_idle", {31'd0, err[0]}, 32'd0);
    req(0, 1'b0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 0, n, e, q, bok, aft);
    check("wr1000_error", {31'd0, e}, 32'd1);
    req(0, 1'b1, 1'b0, 32'h0, 32'h0, 0, n, e, q, bok, aft);
    check("rd0_unchanged", q, 32'h600D_F00D);
    check("rd0_error", {31'd0, e}, 32'd0);

    // Read+write conflict
    req(0, 1'b1, 1'b1, 32'h10, 32'h1111_1111, 0, n, e, q, bok, aft);
    check("conflict_error", {31'd0, e}, 32'd1);
    check("conflict_data", q, 32'd0);
    req(0, 1'b1, 1'b0, 32'h10, 32'h0, 0, n, e, q, bok, aft);
    check("conflict_store", q, 32'hDEAD_BEEF);

    // LATENCY=1, request held through the edge after mem_ready
    req(1, 1'b0, 1'b1, 32'h8, 32'hCAFE_F00D, 1, n, e, q, bok, aft);
    check("l1_wr_latency", n, 32'd1);
    check("l1_wr_no_reaccept", {31'd0, aft}, 32'd0);
    req(1, 1'b1, 1'b0, 32'h8, 32'h0, 1, n, e, q, bok, aft);
    check("l1_rd_latency", n, 32'd1);
    check("l1_rd_data", q, 32'hCAFE_F00D);
    check("l1_rd_no_reaccept", {31'd0, aft}, 32'd0);

    // LATENCY=8
    req(2, 1'b0, 1'b1, 32'h14, 32'h0BAD_CAFE, 1, n, e, q, bok, aft);
    check("l8_wr_latency", n, 32'd8);
    check("l8_wr_no_reaccept", {31'd0, aft}, 32'd0);
    req(2, 1'b1, 1'b0, 32'h14, 32'h0, 0, n, e, q, bok, aft);
    check("l8_rd_latency", n, 32'd8);
    check("l8_rd_data", q, 32'h0BAD_CAFE);
    check("l8_rd_busy", {31'd0, bok}, 32'd1);

    // Reset two cycles into a write: abandoned, no store update
    addr = 32'h40; wdata = 32'hA5A5_A5A5; wr[0] = 1'b1;
    @(posedge clk); #1;
    check("midop_busy", {31'd0, busy[0]}, 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("midop_busy_reset", {31'd0, busy[0]}, 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("midop_no_ready", {31'd0, rdy[0]}, 32'd0);
    end
    wr[0] = 1'b0;
    reset_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("midop_idle_ready", {31'd0, rdy[0] | busy[0]}, 32'd0);
    end
    $display("[TB] inst0 write 40 aborted by reset");
    req(0, 1'b1, 1'b0, 32'h40, 32'h0, 0, n, e, q, bok, aft);
    check("midop_rd40", q, 32'd0);
    check("midop_rd40_latency", n, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
